// File: rtl/execute_stage_pkg.sv
// Shared constants and types for the MIPS execute stage: ALU opcodes,
// forward-select codes and the memory-stage control bundle.
package execute_stage_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic reg_write;
      logic mem_write;
      logic mem_to_reg;
   } mem_ctrl_t;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU of the execute stage; all arithmetic wraps modulo 2^WIDTH.
module exec_alu
   import execute_stage_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic signed [WIDTH-1:0] src_a,
   input  logic signed [WIDTH-1:0] src_b,
   input  logic        [2:0]       alu_control,
   output logic signed [WIDTH-1:0] alu_result
);

   // Signed compare on the operands themselves, so a subtraction overflow
   // cannot flip the answer.
   function automatic logic signed_less(input logic signed [WIDTH-1:0] a,
                                        input logic signed [WIDTH-1:0] b);
      return a < b;
   endfunction

   always_comb begin
      alu_result = '0;
      case (alu_control)
         ALU_AND: alu_result = src_a & src_b;
         ALU_OR:  alu_result = src_a | src_b;
         ALU_ADD: alu_result = src_a + src_b;
         ALU_SUB: alu_result = src_a - src_b;
         ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, signed_less(src_a, src_b)};
         default: alu_result = '0;
      endcase
   end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the five-stage MIPS pipeline: operand forwarding, ALU,
// destination select and the EX/MEM pipeline register.
module execute_stage
   import execute_stage_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             EXST_CLK,
   input  logic             EXST_RST,
   input  logic [WIDTH-1:0] EXST_RD1E,
   input  logic [WIDTH-1:0] EXST_RD2E,
   input  logic [4:0]       EXST_RtE,
   input  logic [4:0]       EXST_RdE,
   input  logic [WIDTH-1:0] EXST_SignImmE,
   input  logic             EXST_RegWriteE,
   input  logic             EXST_MemWriteE,
   input  logic             EXST_MemToRegE,
   input  logic [2:0]       EXST_ALuControlE,
   input  logic             EXST_AluSrcE,
   input  logic             EXST_RegDstE,
   input  logic [1:0]       EXST_ForwardAE,
   input  logic [1:0]       EXST_ForwardBE,
   input  logic [WIDTH-1:0] EXST_ResultW,
   output logic [4:0]       EXST_WriteRegE,
   output logic [WIDTH-1:0] EXST_ALUOutM,
   output logic [WIDTH-1:0] EXST_WriteDataM,
   output logic [4:0]       EXST_WriteRegM,
   output logic             EXST_RegWriteM,
   output logic             EXST_MemWriteM,
   output logic             EXST_MemToRegM
);

   // Select code 11 is unused by the hazard unit and falls back to the register file.
   function automatic logic signed [WIDTH-1:0] fwd_pick(
      input logic        [1:0]       sel,
      input logic signed [WIDTH-1:0] rf_val,
      input logic signed [WIDTH-1:0] wb_val,
      input logic signed [WIDTH-1:0] mem_val);
      case (sel)
         FWD_WB:  return wb_val;
         FWD_MEM: return mem_val;
         default: return rf_val;
      endcase
   endfunction

   logic signed [WIDTH-1:0] src_a_p0;
   logic signed [WIDTH-1:0] fwd_b_p0;
   logic signed [WIDTH-1:0] src_b_p0;
   logic signed [WIDTH-1:0] alu_res_p0;
   logic        [4:0]       write_reg_p0;
   mem_ctrl_t               ctrl_p0;

   logic signed [WIDTH-1:0] alu_out_p1;
   logic signed [WIDTH-1:0] write_data_p1;
   logic        [4:0]       write_reg_p1;
   mem_ctrl_t               ctrl_p1;

   // ---- execute (p0): forwarding, operand select, ALU, destination ----
   assign src_a_p0 = fwd_pick(EXST_ForwardAE, EXST_RD1E, EXST_ResultW, alu_out_p1);
   assign fwd_b_p0 = fwd_pick(EXST_ForwardBE, EXST_RD2E, EXST_ResultW, alu_out_p1);
   assign src_b_p0 = EXST_AluSrcE ? $signed(EXST_SignImmE) : fwd_b_p0;

   assign write_reg_p0 = EXST_RegDstE ? EXST_RdE : EXST_RtE;

   assign ctrl_p0.reg_write  = EXST_RegWriteE;
   assign ctrl_p0.mem_write  = EXST_MemWriteE;
   assign ctrl_p0.mem_to_reg = EXST_MemToRegE;

   exec_alu #(
      .WIDTH(WIDTH)
   ) u_alu (
      .src_a      (src_a_p0),
      .src_b      (src_b_p0),
      .alu_control(EXST_ALuControlE),
      .alu_result (alu_res_p0)
   );

   // ---- EX/MEM register (p1): no enable, bubbles arrive as zeroed control ----
   always_ff @(posedge EXST_CLK or posedge EXST_RST) begin
      if (EXST_RST) begin
         alu_out_p1    <= '0;
         write_data_p1 <= '0;
         write_reg_p1  <= '0;
         ctrl_p1       <= '0;
      end else begin
         alu_out_p1    <= alu_res_p0;
         write_data_p1 <= fwd_b_p0;
         write_reg_p1  <= write_reg_p0;
         ctrl_p1       <= ctrl_p0;
      end
   end

   assign EXST_WriteRegE  = write_reg_p0;
   assign EXST_ALUOutM    = alu_out_p1;
   assign EXST_WriteDataM = write_data_p1;
   assign EXST_WriteRegM  = write_reg_p1;
   assign EXST_RegWriteM  = ctrl_p1.reg_write;
   assign EXST_MemWriteM  = ctrl_p1.mem_write;
   assign EXST_MemToRegM  = ctrl_p1.mem_to_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with a behavioural EX/MEM model checked every cycle.
module tb_execute_stage;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] rd1 = '0, rd2 = '0, imm = '0, resw = '0;
   logic [4:0]   rt = '0, rdn = '0;
   logic         rw = 1'b0, mw = 1'b0, mr = 1'b0, alusrc = 1'b0, regdst = 1'b0;
   logic [2:0]   aluc = '0;
   logic [1:0]   fa = '0, fb = '0;

   logic [4:0]   wre, wrm;
   logic [W-1:0] alu_m, wd_m;
   logic         rw_m, mw_m, mr_m;

   int total = 0;
   int bad   = 0;
   bit run   = 1'b0;

   // Model of the EX/MEM state
   logic [W-1:0] e_alu, e_wd;
   logic [4:0]   e_wr;
   logic         e_rw, e_mw, e_mr;

   always #5 clk = ~clk;

   execute_stage #(.WIDTH(W)) dut (
      .EXST_CLK        (clk),
      .EXST_RST        (rst),
      .EXST_RD1E       (rd1),
      .EXST_RD2E       (rd2),
      .EXST_RtE        (rt),
      .EXST_RdE        (rdn),
      .EXST_SignImmE   (imm),
      .EXST_RegWriteE  (rw),
      .EXST_MemWriteE  (mw),
      .EXST_MemToRegE  (mr),
      .EXST_ALuControlE(aluc),
      .EXST_AluSrcE    (alusrc),
      .EXST_RegDstE    (regdst),
      .EXST_ForwardAE  (fa),
      .EXST_ForwardBE  (fb),
      .EXST_ResultW    (resw),
      .EXST_WriteRegE  (wre),
      .EXST_ALUOutM    (alu_m),
      .EXST_WriteDataM (wd_m),
      .EXST_WriteRegM  (wrm),
      .EXST_RegWriteM  (rw_m),
      .EXST_MemWriteM  (mw_m),
      .EXST_MemToRegM  (mr_m)
   );

   function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] r,
                                         input logic [W-1:0] w, input logic [W-1:0] m);
      if (s == 2'd1) return w;
      if (s == 2'd2) return m;
      return r;
   endfunction

   // SLT from sign bits: differing signs decide directly, otherwise unsigned order.
   function automatic logic [W-1:0] model_alu(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      logic lt;
      lt = (a[W-1] != b[W-1]) ? a[W-1] : (a < b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a + b;
         3'd6: return a + (~b + 1);
         3'd7: return lt ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         e_alu <= '0; e_wd <= '0; e_wr <= '0;
         e_rw <= 1'b0; e_mw <= 1'b0; e_mr <= 1'b0;
      end else begin
         e_alu <= model_alu(aluc, pick(fa, rd1, resw, e_alu),
                            alusrc ? imm : pick(fb, rd2, resw, e_alu));
         e_wd  <= pick(fb, rd2, resw, e_alu);
         e_wr  <= regdst ? rdn : rt;
         e_rw  <= rw; e_mw <= mw; e_mr <= mr;
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run) begin
         check("m_alu",  alu_m, e_alu);
         check("m_wd",   wd_m,  e_wd);
         check("m_wr",   {27'd0, wrm}, {27'd0, e_wr});
         check("m_rw",   {31'd0, rw_m}, {31'd0, e_rw});
         check("m_mw",   {31'd0, mw_m}, {31'd0, e_mw});
         check("m_mr",   {31'd0, mr_m}, {31'd0, e_mr});
         check("m_wre",  {27'd0, wre}, {27'd0, (regdst ? rdn : rt)});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      aluc = c; rd1 = a; rd2 = b; fa = 2'd0; fb = 2'd0; alusrc = 1'b0;
   endtask

   initial begin
      // All inputs nonzero before reset is raised
      rd1 = 32'hF; rd2 = 32'h3; imm = 32'h7; resw = 32'h99;
      rt = 5'd5; rdn = 5'd9; regdst = 1'b1;
      rw = 1'b1; mw = 1'b1; mr = 1'b1; aluc = 3'b010;
      #1 rst = 1'b1;
      #1;
      check("rst_alu", alu_m, 32'h0);
      check("rst_wd",  wd_m,  32'h0);
      check("rst_rw",  {31'd0, rw_m}, 32'h0);
      check("rst_mw",  {31'd0, mw_m}, 32'h0);
      check("rst_wre", {27'd0, wre}, 32'd9);
      run = 1'b1;
      tick();
      check("rst_hold", alu_m, 32'h0);
      rst = 1'b0;
      tick();
      check("first_alu", alu_m, 32'h12);
      check("first_wd",  wd_m,  32'h3);
      check("first_wr",  {27'd0, wrm}, 32'd9);
      check("first_mw",  {31'd0, mw_m}, 32'h1);

      // ALU sweep without forwarding
      rw = 1'b0; mw = 1'b0; mr = 1'b0;
      op(3'b000, 32'hF, 32'h3); tick(); check("and", alu_m, 32'h3);
      op(3'b001, 32'hF, 32'h3); tick(); check("or",  alu_m, 32'hF);
      op(3'b010, 32'hF, 32'h3); tick(); check("add", alu_m, 32'h12);
      op(3'b110, 32'hF, 32'h3); tick(); check("sub", alu_m, 32'hC);
      op(3'b111, 32'hF, 32'h3); tick(); check("slt", alu_m, 32'h0);
      op(3'b101, 32'hF, 32'h3); tick(); check("op101", alu_m, 32'h0);
      op(3'b011, 32'hF, 32'h3); tick(); check("op011", alu_m, 32'h0);
      op(3'b100, 32'hF, 32'h3); tick(); check("op100", alu_m, 32'h0);
      op(3'b111, 32'h80000000, 32'h1); tick(); check("slt_ovf", alu_m, 32'h1);
      op(3'b111, 32'h7FFFFFFF, 32'hFFFFFFFF); tick(); check("slt_pos", alu_m, 32'h0);
      op(3'b110, 32'h3, 32'hF); tick(); check("sub_neg", alu_m, 32'hFFFFFFF4);
      op(3'b010, 32'hFFFFFFFF, 32'h1); tick(); check("add_wrap", alu_m, 32'h0);

      // Forward from own ALUOutM with immediate operand
      op(3'b010, 32'h10, 32'h10); tick(); check("fwd_pre", alu_m, 32'h20);
      op(3'b010, 32'h1, 32'h1); fa = 2'd2; alusrc = 1'b1; imm = 32'h4;
      tick(); check("fwd_mem_a", alu_m, 32'h24);

      // Store data forwarded from writeback
      op(3'b010, 32'h1, 32'h2); fb = 2'd1; resw = 32'h55; mw = 1'b1;
      tick();
      check("fwd_wb_b", wd_m, 32'h55);
      check("fwd_wb_alu", alu_m, 32'h56);
      check("fwd_wb_mw", {31'd0, mw_m}, 32'h1);
      mw = 1'b0;

      // Select 11 uses register-file values
      op(3'b010, 32'h7, 32'h2); fa = 2'd3; fb = 2'd3; resw = 32'h1000;
      tick();
      check("fwd11_alu", alu_m, 32'h9);
      check("fwd11_wd",  wd_m,  32'h2);

      // Destination mux and control pass-through
      op(3'b001, 32'h1, 32'h2);
      rt = 5'd5; rdn = 5'd9; regdst = 1'b0;
      #1 check("wre_rt", {27'd0, wre}, 32'd5);
      regdst = 1'b1;
      #1 check("wre_rd", {27'd0, wre}, 32'd9);
      rw = 1'b1; mw = 1'b0; mr = 1'b1;
      tick();
      check("wrm_rd", {27'd0, wrm}, 32'd9);
      check("ctl_rw", {31'd0, rw_m}, 32'h1);
      check("ctl_mw", {31'd0, mw_m}, 32'h0);
      check("ctl_mr", {31'd0, mr_m}, 32'h1);
      regdst = 1'b0; tick(); check("wrm_rt", {27'd0, wrm}, 32'd5);

      // Reset in mid-operation clears without a clock edge
      op(3'b010, 32'h30, 32'h5); mw = 1'b1;
      tick(); check("pre_rst", alu_m, 32'h35);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_alu", alu_m, 32'h0);
      check("mid_rst_mw",  {31'd0, mw_m}, 32'h0);
      check("mid_rst_rw",  {31'd0, rw_m}, 32'h0);
      tick();
      check("mid_rst_hold", wd_m, 32'h0);
      rst = 1'b0;
      tick();
      check("post_rst_alu", alu_m, 32'h35);
      check("post_rst_mw",  {31'd0, mw_m}, 32'h1);

      rw = 1'b0; mw = 1'b0; mr = 1'b0;
      tick(); tick();
      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
